// File: rtl/dmem_controller_pkg.sv
// Shared types for the data-memory sequencer: size codes, FSM states,
// requester IDs and the latched transaction record.
package dmem_controller_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_BAD  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  typedef struct packed {
    logic        rw;
    logic [1:0]  val;
    logic        uns;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } xact_s;

  // Half needs addr[0]=0, word needs addr[1:0]=0, size 11 is never legal.
  function automatic logic misaligned(input logic [1:0] val, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (val)
      MEM_HALF: bad = lane[0];
      MEM_WORD: bad = |lane;
      MEM_BAD:  bad = 1'b1;
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_controller_lane_align.sv
// Byte/halfword lane handling: extracts and extends load data, and merges
// store data into the word read back from memory.
module dmem_lane_align
  import dmem_controller_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  val,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign byte_sh = {addr, 3'b000};
  assign half_sh = {addr[1], 4'b0000};

  always_comb begin
    lane_b    = word[byte_sh +: 8];
    lane_h    = word[half_sh +: 16];
    load_data = '0;
    merged    = word;
    case (val)
      MEM_BYTE: begin
        load_data              = {{24{lane_b[7] & ~uns}}, lane_b};
        merged[byte_sh +: 8]   = wdata[7:0];
      end
      MEM_HALF: begin
        load_data              = {{16{lane_h[15] & ~uns}}, lane_h};
        merged[half_sh +: 16]  = wdata[15:0];
      end
      MEM_WORD: begin
        load_data = word;
        merged    = wdata;
      end
      default: begin
        load_data = '0;
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_controller.sv
// Round-robin arbiter and sequencer for the single-port word data memory;
// sub-word stores are performed as read-modify-write.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; grants one and latches its fields
// ST_READ  | memory word addressed; load result or merged word captured
// ST_WRITE | mem_rw high for one cycle with the final write word
// ST_RESP  | ack (and err) pulsed to the granted requester
module dmem_controller
  import dmem_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [1:0]  cpu_val,
  input  logic        cpu_uns,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_rw,
  input  logic [1:0]  dbg_val,
  input  logic        dbg_uns,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic [31:0] dbg_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rw,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state;
  req_id_e     last_grant;
  req_id_e     owner;
  xact_s       cur;
  xact_s       sel;
  logic [31:0] sel_addr;
  logic        grant_dbg;
  logic [31:0] load_data;
  logic [31:0] merged;

  // On a tie the requester not served last wins.
  assign grant_dbg = dbg_req & (~cpu_req | (last_grant == REQ_CPU));

  always_comb begin
    sel_addr = grant_dbg ? dbg_addr : cpu_addr;
    sel      = '0;
    if (grant_dbg) begin
      sel.rw    = dbg_rw;
      sel.val   = dbg_val;
      sel.uns   = dbg_uns;
      sel.wdata = dbg_wdata;
    end else begin
      sel.rw    = cpu_rw;
      sel.val   = cpu_val;
      sel.uns   = cpu_uns;
      sel.wdata = cpu_wdata;
    end
    sel.lane = sel_addr[1:0];
  end

  dmem_lane_align u_lane_align (
    .word      (mem_rdata),
    .addr      (cur.lane),
    .val       (cur.val),
    .uns       (cur.uns),
    .wdata     (cur.wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= REQ_DBG;
      owner      <= REQ_CPU;
      cur        <= '0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      dbg_ack    <= 1'b0;
      dbg_err    <= 1'b0;
      dbg_rdata  <= '0;
      mem_addr   <= '0;
      mem_rw     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req || dbg_req) begin
            owner      <= grant_dbg ? REQ_DBG : REQ_CPU;
            last_grant <= grant_dbg ? REQ_DBG : REQ_CPU;
            cur        <= sel;
            mem_addr   <= {sel_addr[31:2], 2'b00};
            if (misaligned(sel.val, sel.lane)) begin
              cpu_ack <= ~grant_dbg;
              cpu_err <= ~grant_dbg;
              dbg_ack <= grant_dbg;
              dbg_err <= grant_dbg;
              state   <= ST_RESP;
            end else if (sel.rw && (sel.val == MEM_WORD)) begin
              mem_rw    <= 1'b1;
              mem_wdata <= sel.wdata;
              state     <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (cur.rw) begin
            mem_rw    <= 1'b1;
            mem_wdata <= merged;
            state     <= ST_WRITE;
          end else begin
            cpu_ack   <= (owner == REQ_CPU);
            dbg_ack   <= (owner == REQ_DBG);
            cpu_rdata <= (owner == REQ_CPU) ? load_data : '0;
            dbg_rdata <= (owner == REQ_DBG) ? load_data : '0;
            state     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          mem_rw    <= 1'b0;
          mem_wdata <= '0;
          cpu_ack   <= (owner == REQ_CPU);
          dbg_ack   <= (owner == REQ_DBG);
          state     <= ST_RESP;
        end
        ST_RESP: begin
          cpu_ack   <= 1'b0;
          cpu_err   <= 1'b0;
          cpu_rdata <= '0;
          dbg_ack   <= 1'b0;
          dbg_err   <= 1'b0;
          dbg_rdata <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench for dmem_controller with a word-array memory model.
module tb_dmem_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rw, cpu_uns;
  logic [1:0]  cpu_val;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_err;
  logic        dbg_req, dbg_rw, dbg_uns;
  logic [1:0]  dbg_val;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_ack, dbg_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rw;

  logic [31:0] mem [0:255];
  logic        poke_en = 1'b0;
  logic [31:0] poke_addr = '0;
  logic [31:0] poke_data = '0;
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  dmem_controller dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_rw    (cpu_rw),
    .cpu_val   (cpu_val),
    .cpu_uns   (cpu_uns),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_rw    (dbg_rw),
    .dbg_val   (dbg_val),
    .dbg_uns   (dbg_uns),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_err   (dbg_err),
    .dbg_rdata (dbg_rdata),
    .mem_addr  (mem_addr),
    .mem_rw    (mem_rw),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr[9:2]] <= poke_data;
    else if (mem_rw) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  // One transaction from one requester; latencies counted from the IDLE grant cycle.
  task automatic xact(input string tag, input bit dbg, input logic rw, input logic [1:0] val,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                      input int exp_wr);
    int lat, wr_at;
    logic other, wd_clean, err_s;
    logic [31:0] rd_s;
    lat = -1; wr_at = -1; other = 1'b0; wd_clean = 1'b1; err_s = 1'b0; rd_s = '0;
    if (dbg) begin
      dbg_rw = rw; dbg_val = val; dbg_uns = uns; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    end else begin
      cpu_rw = rw; cpu_val = val; cpu_uns = uns; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (mem_rw) wr_at = (wr_at < 0) ? n : 99;
      else if (mem_wdata != 32'h0) wd_clean = 1'b0;
      if (dbg ? cpu_ack : dbg_ack) other = 1'b1;
      if (dbg ? dbg_ack : cpu_ack) begin
        lat   = n;
        err_s = dbg ? dbg_err : cpu_err;
        rd_s  = dbg ? dbg_rdata : cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    chk({tag, " ack cycle"}, 32'(lat), 32'(exp_lat));
    chk({tag, " err"}, {31'b0, err_s}, {31'b0, exp_err});
    chk({tag, " rdata"}, rd_s, exp_rdata);
    chk({tag, " write cycle"}, 32'(wr_at), 32'(exp_wr));
    chk({tag, " wrong ack"}, {31'b0, other}, 32'h0);
    chk({tag, " idle wdata"}, {31'b0, wd_clean}, 32'h1);
    tick();
    chk({tag, " ack width"}, {30'b0, cpu_ack, dbg_ack}, 32'h0);
  endtask

  // Both requesters raise req together; cpu optionally re-requests once right after its first ack.
  task automatic race(input bit rearm, output int c1, output int c2, output int d,
                      output logic [31:0] crd, output logic [31:0] drd);
    bit again;
    c1 = -1; c2 = -1; d = -1; crd = '0; drd = '0; again = 1'b0;
    cpu_req = 1'b1;
    dbg_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (again) begin cpu_req = 1'b1; again = 1'b0; end
      if (cpu_ack) begin
        cpu_req = 1'b0;
        if (c1 < 0) begin c1 = n; crd = cpu_rdata; again = rearm; end
        else c2 = n;
      end
      if (dbg_ack) begin d = n; drd = dbg_rdata; dbg_req = 1'b0; end
      if (d >= 0 && c1 >= 0 && (!rearm || c2 >= 0)) break;
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
  endtask

  int c1, c2, d, wr0;
  logic [31:0] crd, drd;
  logic stray;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_rw = 0; cpu_val = 0; cpu_uns = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_rw = 0; dbg_val = 0; dbg_uns = 0; dbg_addr = 0; dbg_wdata = 0;
    tick();
    tick();
    chk("reset acks/errs/rw", {27'b0, cpu_ack, cpu_err, dbg_ack, dbg_err, mem_rw}, 32'h0);
    chk("reset cpu_rdata", cpu_rdata, 32'h0);
    chk("reset dbg_rdata", dbg_rdata, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    tick();

    poke(32'h100, 32'h8123_45F6);
    poke(32'h104, 32'hDEAD_BEEF);
    poke(32'h108, 32'h0000_0000);
    poke(32'h10C, 32'h5566_7788);

    xact("LW 100",  0, 0, 2'b10, 0, 32'h100, 0, 2, 0, 32'h8123_45F6, -1);
    xact("LB 103",  0, 0, 2'b00, 0, 32'h103, 0, 2, 0, 32'hFFFF_FF81, -1);
    xact("LBU 103", 0, 0, 2'b00, 1, 32'h103, 0, 2, 0, 32'h0000_0081, -1);
    xact("LH 102",  0, 0, 2'b01, 0, 32'h102, 0, 2, 0, 32'hFFFF_8123, -1);
    xact("LHU 102", 0, 0, 2'b01, 1, 32'h102, 0, 2, 0, 32'h0000_8123, -1);
    xact("LB 100",  0, 0, 2'b00, 0, 32'h100, 0, 2, 0, 32'hFFFF_FFF6, -1);
    xact("LBU 101", 0, 0, 2'b00, 1, 32'h101, 0, 2, 0, 32'h0000_0045, -1);

    poke(32'h100, 32'h1122_3344);
    xact("SB 101", 0, 1, 2'b00, 0, 32'h101, 32'hFFFF_FFAA, 3, 0, 32'h0, 2);
    chk("SB 101 mem", mem[8'h40], 32'h1122_AA44);
    xact("dbg SH 106", 1, 1, 2'b01, 0, 32'h106, 32'hABCD_1234, 3, 0, 32'h0, 2);
    chk("SH 106 mem", mem[8'h41], 32'h1234_BEEF);
    xact("dbg LH 104",  1, 0, 2'b01, 0, 32'h104, 0, 2, 0, 32'hFFFF_BEEF, -1);
    xact("dbg LHU 106", 1, 0, 2'b01, 1, 32'h106, 0, 2, 0, 32'h0000_1234, -1);
    xact("SW 108", 0, 1, 2'b10, 0, 32'h108, 32'hCAFE_F00D, 2, 0, 32'h0, 1);
    chk("SW 108 mem", mem[8'h42], 32'hCAFE_F00D);
    xact("dbg LB 10B", 1, 0, 2'b00, 0, 32'h10B, 0, 2, 0, 32'hFFFF_FFCA, -1);

    wr0 = wr_cnt;
    xact("SW 102 misaligned", 0, 1, 2'b10, 0, 32'h102, 32'h0BAD_0BAD, 1, 1, 32'h0, -1);
    xact("size 11",           0, 0, 2'b11, 0, 32'h100, 0, 1, 1, 32'h0, -1);
    xact("SH 101 misaligned", 0, 1, 2'b01, 0, 32'h101, 32'h0000_5555, 1, 1, 32'h0, -1);
    xact("dbg LW 105",        1, 0, 2'b10, 0, 32'h105, 0, 1, 1, 32'h0, -1);
    chk("error writes", 32'(wr_cnt - wr0), 32'h0);
    chk("error mem unchanged", mem[8'h40], 32'h1122_AA44);

    cpu_rw = 0; cpu_val = 2'b10; cpu_uns = 0; cpu_addr = 32'h100;
    dbg_rw = 0; dbg_val = 2'b10; dbg_uns = 0; dbg_addr = 32'h104;
    race(1'b1, c1, c2, d, crd, drd);
    chk("race cpu first ack", 32'(c1), 32'd2);
    chk("race dbg ack", 32'(d), 32'd5);
    chk("race cpu second ack", 32'(c2), 32'd8);
    chk("race cpu rdata", crd, 32'h1122_AA44);
    chk("race dbg rdata", drd, 32'h1234_BEEF);

    wr0 = wr_cnt;
    cpu_rw = 1; cpu_val = 2'b00; cpu_uns = 0; cpu_addr = 32'h10C; cpu_wdata = 32'h0000_0011;
    cpu_req = 1'b1;
    tick();
    chk("abort READ addr", mem_addr, 32'h0000_010C);
    reset = 1'b1;
    #1;
    chk("abort outputs", {27'b0, cpu_ack, cpu_err, dbg_ack, dbg_err, mem_rw}, 32'h0);
    chk("abort mem_addr", mem_addr, 32'h0);
    chk("abort mem_wdata", mem_wdata, 32'h0);
    cpu_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    stray = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (mem_rw || cpu_ack || dbg_ack) stray = 1'b1;
    end
    chk("abort no activity", {31'b0, stray}, 32'h0);
    chk("abort no write", 32'(wr_cnt - wr0), 32'h0);
    chk("abort mem unchanged", mem[8'h43], 32'h5566_7788);

    cpu_rw = 0; cpu_val = 2'b10; cpu_uns = 0; cpu_addr = 32'h10C;
    dbg_rw = 0; dbg_val = 2'b10; dbg_uns = 0; dbg_addr = 32'h100;
    race(1'b0, c1, c2, d, crd, drd);
    chk("post-reset cpu ack", 32'(c1), 32'd2);
    chk("post-reset dbg ack", 32'(d), 32'd5);
    chk("post-reset cpu rdata", crd, 32'h5566_7788);
    chk("post-reset dbg rdata", drd, 32'h1122_AA44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_controller.md
# dmem_controller

Sequencer and arbiter for the word-organised data memory of the three-stage RV32IS core. Accepts load/store requests from two requesters (execute stage `cpu_*`, debug/loader `dbg_*`), arbitrates round-robin, and drives the memory's single word port. Byte and halfword stores become read-modify-write sequences; loads are lane-extracted and sign- or zero-extended before return.

## Interface
- No parameters; widths fixed at 32-bit address/data.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_req` / `dbg_req` in 1: request pending; hold fields stable until `ack`.
- `cpu_rw` / `dbg_rw` in 1: 1 = store, 0 = load.
- `cpu_val` / `dbg_val` in 2: size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `cpu_uns` / `dbg_uns` in 1: zero-extend load (LBU/LHU).
- `cpu_addr` / `dbg_addr` in 32: byte address.
- `cpu_wdata` / `dbg_wdata` in 32: store data, right-justified.
- `cpu_ack` / `dbg_ack` out 1: one-cycle completion pulse.
- `cpu_err` / `dbg_err` out 1: valid with `ack`; misaligned or illegal size.
- `cpu_rdata` / `dbg_rdata` out 32: extended load data, valid with `ack`.
- `mem_addr` out 32: word-aligned byte address to memory (bits [1:0] = 0).
- `mem_rw` out 1: 1 = write this cycle.
- `mem_wdata` out 32: merged write word.
- `mem_rdata` in 32: combinational read data for `mem_addr`.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: if any `req` is high, grant one requester and latch its rw/val/uns/addr/wdata.
  - Misaligned or illegal request goes to RESP with err. Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or val=11.
  - Load or sub-word store goes to READ. Word store goes to WRITE.
- READ: `mem_addr`={addr[31:2],2'b00}, `mem_rw`=0. Capture `mem_rdata`.
  - Load: compute extended result, then RESP.
  - Store: merge wdata into the addressed lane(s), then WRITE.
- WRITE: `mem_rw`=1 for exactly one cycle, with `mem_wdata` = merged word (full wdata for word stores). Then RESP.
- RESP: pulse the granted requester's `ack`. `rdata` is driven for loads, 0 for stores and errors. Then IDLE.
- Lane rules:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Load extension uses bit 7 or 15 of the extracted lane, unless `uns`.
  - Store merge preserves all non-addressed bytes.
- Arbitration:
  - Round-robin on `last_grant`; when both request, grant the one not granted last.
  - `last_grant` resets to dbg, so cpu wins the first tie.
  - Only one transaction is in flight. A request arriving mid-transaction waits in IDLE.
- Memory errors never write memory and never touch `last_grant` ordering differently from normal grants.

## Timing
- Cycle 0 is the IDLE cycle in which a req is sampled and granted.
- `ack` arrival:
  - Load: cycle 2.
  - Word store: cycle 2 (write at cycle 1).
  - Sub-word store: cycle 3 (read 1, write 2).
  - Error: cycle 1.
- `mem_rw` is high only in WRITE. In all other states `mem_rw`=0 and `mem_wdata`=0.
- Requester must drop `req` in the cycle after `ack`. If `req` is still high in the following IDLE, it is a new request.
- Back-to-back: the next grant is earliest in the cycle after RESP.
- Simultaneous requests in IDLE: exactly one grant; the loser is served immediately after.
- Reset values:
  - state=IDLE, `last_grant`=dbg.
  - All `ack`, `err`, `rdata` = 0.
  - `mem_rw`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset asserted mid-transaction aborts it immediately. No subsequent write occurs and no `ack` is issued; the requester must re-issue.

## Structure
- `riscv.vh` gains:
  - Size codes `MEM_BYTE`/`MEM_HALF`/`MEM_WORD`.
  - State encodings.
  - Requester IDs `REQ_CPU`/`REQ_DBG`.
- One combinational sub-module, `dmem_lane_align`. Inputs: word, addr[1:0], val, uns, wdata. Outputs: extended load data and merged store word. Instantiated once; the controller contains only FSM, arbitration and latches.

## Test plan
- cpu load word at 0x100 with memory word 0x8123_45F6 → `cpu_ack` at cycle 2, `cpu_rdata`=0x8123_45F6, `err`=0.
- cpu LB at 0x103 → `rdata`=0xFFFF_FF81. LBU at the same address → 0x0000_0081. LH at 0x102 → 0xFFFF_8123.
- cpu SB 0xAA at 0x101, memory initially 0x1122_3344 → READ at cycle 1, write at cycle 2 of 0x1122_AA44, `ack` at cycle 3.
- cpu and dbg request at the same cycle after reset → cpu acked first. dbg is granted the cycle after cpu's RESP. With both re-requesting, alternation continues.
- Word store at 0x102, and val=11 → `ack`+`err` at cycle 1, `mem_rw` never asserted, memory unchanged.
- `reset` pulsed during READ of a sub-word store → no `mem_rw` pulse, no `ack`, all outputs 0. The next request completes normally.
